wb_uart_fifo: RTL
=================

Name: wb_uart_fifo

Overview:
Buffered Wishbone UART peripheral that replaces the unbuffered uart0 slave at 0x70000000.
- 8N1 serial receive and transmit engines sit behind separate RX and TX FIFOs.
- Provides a runtime-programmable baud divisor.
- Provides a level interrupt that drives the LM32 intr_n[0] line, which is currently tied inactive.

Parameters:
- clk_freq, 50000000, system clock in Hz.
- baud, 115200, reset baud rate; reset divisor = clk_freq/baud, integer division.
- fifo_aw, 4, log2 FIFO depth; 16 entries each for RX and TX.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wb_adr_i  in  32  byte address; only [3:2] decoded.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_stb_i, wb_cyc_i, wb_we_i  in  1 each  Wishbone classic strobe, cycle and write enable.
- wb_sel_i  in  4  byte selects; ignored, every access is a full-word access.
- wb_ack_o  out  1  acknowledge.
- intr  out  1  active-high level interrupt.
- uart_rxd  in  1  serial input; asynchronous, idle high.
- uart_txd  out  1  serial output.

Behaviour:
- Reset values:
  - wb_ack_o=0, wb_dat_o=0, intr=0, uart_txd=1.
  - Both FIFOs empty; all sticky flags clear.
  - CTRL=0; DIV=clk_freq/baud.
  - RX and TX engines in IDLE; RX synchroniser flops preset to 1.
- Wishbone handshake:
  - wb_ack_o rises the cycle after stb&cyc&~ack and lasts exactly one cycle, so throughput is at most one access per 2 cycles.
  - Side effects (FIFO push/pop, register write) occur in the ack cycle only.
  - wb_dat_o is valid in the ack cycle.
- Register map (word offsets):
  - 0x0 DATA
    - Read: pops RX FIFO and returns [7:0]=byte, [8]=1 if a byte was popped. On empty it returns 0 with no state change.
    - Write: pushes wb_dat_i[7:0] into the TX FIFO. If TX is full, the byte is dropped and TXDROP is set.
  - 0x4 STATUS
    - [0] RXAVAIL (RX FIFO non-empty).
    - [1] TXFULL.
    - [2] TXIDLE (TX FIFO empty and TX engine in IDLE).
    - [3] RXOVR, sticky.
    - [4] FRAMERR, sticky.
    - [5] TXDROP, sticky.
    - [12:8] rx_count; [20:16] tx_count.
    - Write: 1 to bits [5:3] clears the corresponding sticky flags. A set event in the same cycle wins over the clear.
  - 0x8 CTRL: [0] rx_ie, [1] tx_ie, [2] err_ie; read/write.
  - 0xC DIV: [15:0] read/write. Written values below 4 are stored as 4.
- intr = (rx_ie & RXAVAIL) | (tx_ie & TXIDLE) | (err_ie & (RXOVR|FRAMERR|TXDROP)), registered one cycle.
- FIFOs:
  - Simultaneous push and pop on a non-empty FIFO: both occur and the count is unchanged.
  - Push on full is rejected. Pop on empty is ignored.
  - Pointers wrap modulo 2^fifo_aw; count ranges 0..2^fifo_aw.
- RX engine (input through a 2-flop synchroniser); states IDLE, START, DATA, STOP:
  - IDLE: a falling edge on the synchronised input latches DIV into a local divisor and moves to START.
  - START: after div/2 cycles, sample the line. Low goes to DATA; high is a glitch and returns to IDLE.
  - DATA: sample every div cycles, LSB first, 8 bits.
  - STOP: sample after div cycles.
    - High: push the byte; if RX is full, drop it and set RXOVR.
    - Low: drop the byte, set FRAMERR, and wait for the line to return high before going to IDLE.
- TX engine; states IDLE, START, DATA, STOP:
  - IDLE: when the TX FIFO is non-empty, pop a byte, latch DIV, drive 0 for div cycles (START).
  - DATA: 8 bits LSB first, div cycles each.
  - STOP: 1 for div cycles, then IDLE. The next byte may start in the cycle after STOP ends, giving back-to-back frames of 10*div cycles.
- A DIV write mid-frame affects only frames started afterwards.
- reset_n asserted mid-frame aborts immediately: uart_txd returns to 1 and FIFO contents are lost.

Decomposition:
- Package uart_pkg:
  - Register offsets (REG_DATA, REG_STATUS, REG_CTRL, REG_DIV).
  - STATUS bit indices.
  - Engine state enum (IDLE/START/DATA/STOP).
  - DIV_MIN=4.
- Sub-module sync_fifo (parameters width=8, aw=fifo_aw; push/pop/full/empty/count), instantiated twice.
- RX and TX engines stay inline in wb_uart_fifo.

Test Plan:
- DIV:=16; write 0x55 to DATA → uart_txd low for 16 cycles, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then high; TXIDLE=1 160 cycles after the first start-bit cycle.
- Loop uart_txd to uart_rxd, DIV=16, write 0xA3 then 0x0F → two DATA reads return 0x1A3 and 0x10F; a third read returns 0x000.
- With no DATA reads, inject 17 frames → rx_count=16 and RXOVR=1; write STATUS=0x8 → RXOVR=0 and rx_count stays 16.
- Inject a frame with stop bit 0 → FRAMERR=1 and no push; a 3-cycle low glitch on uart_rxd with DIV=16 → no push and no flag set.
- CTRL=1 with RX empty → intr=0; after one received byte intr=1; after popping it intr=0 within 2 cycles.
- Write 17 bytes while TX is busy → TXDROP=1 and tx_count=16; assert reset_n=0 mid-frame → uart_txd=1 and tx_count=0 immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered Wishbone UART: register map,
// STATUS bit positions, serial engine states and the divisor floor.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int ST_RXAVAIL     = 0;
  localparam int ST_TXFULL      = 1;
  localparam int ST_TXIDLE      = 2;
  localparam int ST_RXOVR       = 3;
  localparam int ST_FRAMERR     = 4;
  localparam int ST_TXDROP      = 5;
  localparam int ST_RXCOUNT_LSB = 8;
  localparam int ST_TXCOUNT_LSB = 16;

  localparam logic [15:0] DIV_MIN = 16'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} eng_state_e;

  // Divisors below the floor leave too few cycles for mid-bit sampling.
  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; rdata always presents the oldest entry.
module sync_fifo #(
  parameter int width = 8,
  parameter int aw    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [width-1:0] wdata,
  input  logic             pop,
  output logic [width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [aw:0]      count
);

  localparam int          DEPTH   = 1 << aw;
  localparam logic [aw-1:0] PTR_ONE = aw'(1);
  localparam logic [aw:0]   CNT_ONE = (aw + 1)'(1);

  logic [width-1:0] mem_q [DEPTH];
  logic [aw-1:0]    wr_ptr_q, wr_ptr_d;
  logic [aw-1:0]    rd_ptr_q, rd_ptr_d;
  logic [aw:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (aw + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Qualify requests: pushes on full and pops on empty are ignored.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage array carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wb_uart_fifo.sv
// Buffered Wishbone UART: 8N1 RX/TX engines behind 16-entry FIFOs,
// programmable baud divisor and a registered level interrupt.
module wb_uart_fifo
  import uart_pkg::*;
#(
  parameter int clk_freq = 50000000,
  parameter int baud     = 115200,
  parameter int fifo_aw  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        intr,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  localparam logic [15:0] DIV_RESET = 16'(clk_freq / baud);

  logic        ack_q, ack_d;
  logic        access, wr_en, rd_en;
  logic [1:0]  reg_sel;
  logic [31:0] rdata, status_word;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [15:0] div_q, div_d;
  logic        rxovr_q, rxovr_d, framerr_q, framerr_d, txdrop_q, txdrop_d;
  logic        intr_q, intr_d;
  logic        rxovr_set, framerr_set, txdrop_set, sticky_clr;

  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_rdata;
  logic [fifo_aw:0] rx_count;
  logic        tx_push, tx_pop, tx_full, tx_empty, tx_idle;
  logic [7:0]  tx_rdata;
  logic [fifo_aw:0] tx_count;

  logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  eng_state_e  rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_break_q, rx_break_d;

  eng_state_e  tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;
  logic        tx_load;

  logic unused_ok;
  assign unused_ok = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16]};

  assign reg_sel  = wb_adr_i[3:2];
  assign access   = ack_q & wb_stb_i & wb_cyc_i;
  assign wr_en    = access & wb_we_i;
  assign rd_en    = access & ~wb_we_i;
  assign wb_ack_o = ack_q;
  assign wb_dat_o = ack_q ? rdata : 32'd0;
  assign intr     = intr_q;
  assign uart_txd = txd_q;
  assign tx_idle  = tx_empty & (tx_state_q == IDLE);

  sync_fifo #(.width(8), .aw(fifo_aw)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push(rx_push), .wdata(rx_shift_q),
    .pop(rx_pop), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty),
    .count(rx_count)
  );

  sync_fifo #(.width(8), .aw(fifo_aw)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push(tx_push), .wdata(wb_dat_i[7:0]),
    .pop(tx_pop), .rdata(tx_rdata), .full(tx_full), .empty(tx_empty),
    .count(tx_count)
  );

  // Bus handshake, register writes, sticky flags and the interrupt level.
  always_comb begin
    ack_d      = wb_stb_i & wb_cyc_i & ~ack_q;
    rx_pop     = rd_en & (reg_sel == REG_DATA);
    tx_push    = wr_en & (reg_sel == REG_DATA);
    txdrop_set = tx_push & tx_full;
    sticky_clr = wr_en & (reg_sel == REG_STATUS);
    ctrl_d     = ctrl_q;
    div_d      = div_q;
    if (wr_en && reg_sel == REG_CTRL) ctrl_d = wb_dat_i[2:0];
    if (wr_en && reg_sel == REG_DIV)  div_d  = clamp_div(wb_dat_i[15:0]);
    rxovr_d   = rxovr_set   | (rxovr_q   & ~(sticky_clr & wb_dat_i[ST_RXOVR]));
    framerr_d = framerr_set | (framerr_q & ~(sticky_clr & wb_dat_i[ST_FRAMERR]));
    txdrop_d  = txdrop_set  | (txdrop_q  & ~(sticky_clr & wb_dat_i[ST_TXDROP]));
    intr_d    = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_idle) |
                (ctrl_q[2] & (rxovr_q | framerr_q | txdrop_q));
  end

  // Assemble STATUS and select read data by word offset.
  always_comb begin
    status_word                          = '0;
    status_word[ST_RXAVAIL]              = ~rx_empty;
    status_word[ST_TXFULL]               = tx_full;
    status_word[ST_TXIDLE]               = tx_idle;
    status_word[ST_RXOVR]                = rxovr_q;
    status_word[ST_FRAMERR]              = framerr_q;
    status_word[ST_TXDROP]               = txdrop_q;
    status_word[ST_RXCOUNT_LSB +: 5]     = 5'(rx_count);
    status_word[ST_TXCOUNT_LSB +: 5]     = 5'(tx_count);
    rdata = '0;
    case (reg_sel)
      REG_DATA:   if (!rx_empty) rdata = {23'd0, 1'b1, rx_rdata};
      REG_STATUS: rdata = status_word;
      REG_CTRL:   rdata = {29'd0, ctrl_q};
      REG_DIV:    rdata = {16'd0, div_q};
      default:    rdata = '0;
    endcase
  end

  // RX engine: synchronise the line, find the start edge, sample mid-bit.
  always_comb begin
    rx_s1_d     = uart_rxd;
    rx_s2_d     = rx_s1_q;
    rx_prev_d   = rx_s2_q;
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + 16'd1;
    rx_div_d    = rx_div_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_break_d  = rx_break_q;
    rx_push     = 1'b0;
    rxovr_set   = 1'b0;
    framerr_set = 1'b0;
    case (rx_state_q)
      IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) begin
          rx_div_d   = div_q;
          rx_state_d = START;
        end
      end
      START: begin
        if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = STOP;
        end
      end
      STOP: begin
        if (rx_break_q) begin
          rx_cnt_d = '0;
          if (rx_s2_q) begin
            rx_break_d = 1'b0;
            rx_state_d = IDLE;
          end
        end else if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_cnt_d = '0;
          if (rx_s2_q) begin
            rx_push    = ~rx_full;
            rxovr_set  = rx_full;
            rx_state_d = IDLE;
          end else begin
            framerr_set = 1'b1;
            rx_break_d  = 1'b1;
          end
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // TX engine: shift out start, 8 data bits LSB first, stop; reload back to back.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_load    = 1'b0;
    case (tx_state_q)
      IDLE: begin
        tx_cnt_d = '0;
        txd_d    = 1'b1;
        tx_load  = ~tx_empty;
      end
      START: begin
        if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_state_d = DATA;
        end
      end
      DATA: begin
        if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end
      end
      STOP: begin
        if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_cnt_d   = '0;
          tx_state_d = IDLE;
          tx_load    = ~tx_empty;
        end
      end
      default: tx_state_d = IDLE;
    endcase
    if (tx_load) begin
      tx_div_d   = div_q;
      tx_shift_d = tx_rdata;
      tx_cnt_d   = '0;
      txd_d      = 1'b0;
      tx_state_d = START;
    end
  end

  assign tx_pop = tx_load;

  // All control state; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q      <= 1'b0;
      ctrl_q     <= '0;
      div_q      <= DIV_RESET;
      rxovr_q    <= 1'b0;
      framerr_q  <= 1'b0;
      txdrop_q   <= 1'b0;
      intr_q     <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_RESET;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_break_q <= 1'b0;
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DIV_RESET;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      ack_q      <= ack_d;
      ctrl_q     <= ctrl_d;
      div_q      <= div_d;
      rxovr_q    <= rxovr_d;
      framerr_q  <= framerr_d;
      txdrop_q   <= txdrop_d;
      intr_q     <= intr_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_break_q <= rx_break_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

endmodule
